// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared FSM state encodings and stats counter width for the mux_arbiter slice
package mux_arbiter_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  localparam int STATS_W = 16;
endpackage

// File: rtl/mux_arb_out_reg.sv
// mux_arb_out_reg: registered valid/data output stage; ports clk rst, load_valid/load_data in, down_ready in, can_load/valid/data out
module mux_arb_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  down_ready,
  output logic                  can_load,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);
  assign can_load = ~valid | down_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (can_load) begin
      valid <= load_valid;
      if (load_valid) data <= load_data;
    end
  end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: 2-source round-robin burst arbiter + 2:1 mux onto a registered valid/ready port; ports clk_i rst_i, valid_k_i data_k_i ready_k_o, valid_o data_o ready_i select_o; MUX_ARB_STATS_EN adds beats_0_o/beats_1_o
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_0_i,
  input  logic [DATA_WIDTH-1:0] data_0_i,
  output logic                  ready_0_o,
  input  logic                  valid_1_i,
  input  logic [DATA_WIDTH-1:0] data_1_i,
  output logic                  ready_1_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
`ifdef MUX_ARB_STATS_EN
  output logic [STATS_W-1:0]    beats_0_o,
  output logic [STATS_W-1:0]    beats_1_o,
`endif
  output logic                  select_o
);
  localparam int CW = $clog2(BURST_LEN + 1);
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last_q, last_n, can_load, xfer_0, xfer_1, xfer, own_v, oth_v, burst_end;
  logic [1:0] oth_state;
  assign select_o  = state == GNT1;
  assign ready_0_o = (state == GNT0) & can_load;
  assign ready_1_o = (state == GNT1) & can_load;
  assign xfer_0    = valid_0_i & ready_0_o;
  assign xfer_1    = valid_1_i & ready_1_o;
  assign xfer      = xfer_0 | xfer_1;
  assign own_v     = select_o ? valid_1_i : valid_0_i;
  assign oth_v     = select_o ? valid_0_i : valid_1_i;
  assign oth_state = select_o ? GNT0 : GNT1;
  assign burst_end = cnt == CW'(BURST_LEN - 1);
  always_comb begin
    state_n = state;
    last_n  = last_q;
    cnt_n   = cnt;
    if (state != GNT0 && state != GNT1) begin
      state_n = IDLE;
      if (valid_0_i || valid_1_i) begin
        last_n  = (valid_0_i && valid_1_i) ? ~last_q : valid_1_i;
        state_n = last_n ? GNT1 : GNT0;
        cnt_n   = '0;
      end
    end else if (can_load) begin
      if (xfer) begin
        cnt_n = burst_end ? '0 : cnt + 1'b1;
        if (burst_end && oth_v) begin
          state_n = oth_state;
          last_n  = ~select_o;
        end
      end else if (!own_v) begin
        cnt_n   = '0;
        state_n = oth_v ? oth_state : IDLE;
        last_n  = oth_v ? ~select_o : last_q;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      last_q <= 1'b1;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      last_q <= last_n;
      cnt    <= cnt_n;
    end
  end
  mux_arb_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk       (clk_i),
    .rst       (rst_i),
    .load_valid(xfer),
    .load_data (select_o ? data_1_i : data_0_i),
    .down_ready(ready_i),
    .can_load  (can_load),
    .valid     (valid_o),
    .data      (data_o)
  );
`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beats_0_o <= '0;
      beats_1_o <= '0;
    end else begin
      if (xfer_0) beats_0_o <= beats_0_o + 1'b1;
      if (xfer_1) beats_1_o <= beats_1_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: table-driven vectors plus scoreboarded sequences for mux_arbiter
module tb_mux_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1, valid_0_i = 1'b0, valid_1_i = 1'b0, ready_i = 1'b1;
  logic [7:0] data_0_i = '0, data_1_i = '0, data_o;
  logic ready_0_o, ready_1_o, valid_o, select_o;
`ifdef MUX_ARB_STATS_EN
  logic [15:0] beats_0_o, beats_1_o;
`endif
  mux_arbiter #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_0_i(valid_0_i), .data_0_i(data_0_i), .ready_0_o(ready_0_o),
    .valid_1_i(valid_1_i), .data_1_i(data_1_i), .ready_1_o(ready_1_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
`ifdef MUX_ARB_STATS_EN
    .beats_0_o(beats_0_o), .beats_1_o(beats_1_o),
`endif
    .select_o(select_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic [3:0] in;
    logic       vo;
    logic [7:0] d;
    logic [2:0] fl;
  } vec_t;
  vec_t tbl[18];
  int checks = 0, errors = 0, cyc = 0, consumed = 0, first_c = -1, last_c = -1;
  int idx0 = 0, idx1 = 0, lim0 = 1000, lim1 = 1000;
  logic rst = 1'b1, en0 = 1'b0, en1 = 1'b0, rdy = 1'b1, use_sb = 1'b0;
  logic [7:0] base0 = 8'h00, base1 = 8'h80;
  logic [7:0] sb[$];
  function automatic vec_t mk(input logic [3:0] in, input logic vo, input logic [7:0] d, input logic [2:0] fl);
    mk.in = in;
    mk.vo = vo;
    mk.d  = d;
    mk.fl = fl;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    logic acc0, acc1;
    @(negedge clk_i);
    rst_i     = rst;
    ready_i   = rdy;
    valid_0_i = en0 && idx0 < lim0;
    valid_1_i = en1 && idx1 < lim1;
    data_0_i  = base0 + 8'(idx0);
    data_1_i  = base1 + 8'(idx1);
    #1;
    acc0 = !rst && valid_0_i && ready_0_o === 1'b1;
    acc1 = !rst && valid_1_i && ready_1_o === 1'b1;
    if (use_sb && !rst && valid_o === 1'b1 && ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %0h expected no beat", data_o);
      end else chk("sb_data", {24'h0, data_o}, {24'h0, sb.pop_front()});
      consumed++;
      if (first_c < 0) first_c = cyc;
      last_c = cyc;
    end
    @(posedge clk_i);
    cyc++;
    if (acc0) idx0++;
    if (acc1) idx1++;
    #1;
  endtask
  task automatic reset_all();
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
    consumed = 0; first_c = -1; last_c = -1;
    idx0 = 0; idx1 = 0; lim0 = 1000; lim1 = 1000;
    base0 = 8'h00; base1 = 8'h80;
  endtask
  initial begin
    // in = {rst, v0, v1, ready_i}; fl = {select_o, ready_0_o, ready_1_o}
    tbl[0]  = mk(4'b1111, 1'b0, 8'h00, 3'b000);
    tbl[1]  = mk(4'b1111, 1'b0, 8'h00, 3'b000);
    tbl[2]  = mk(4'b0111, 1'b0, 8'h00, 3'b010);
    tbl[3]  = mk(4'b0111, 1'b1, 8'h00, 3'b010);
    tbl[4]  = mk(4'b0111, 1'b1, 8'h01, 3'b010);
    tbl[5]  = mk(4'b0111, 1'b1, 8'h02, 3'b010);
    tbl[6]  = mk(4'b0111, 1'b1, 8'h03, 3'b101);
    tbl[7]  = mk(4'b0111, 1'b1, 8'h80, 3'b101);
    tbl[8]  = mk(4'b0111, 1'b1, 8'h81, 3'b101);
    tbl[9]  = mk(4'b0110, 1'b1, 8'h81, 3'b100);
    tbl[10] = mk(4'b0110, 1'b1, 8'h81, 3'b100);
    tbl[11] = mk(4'b0110, 1'b1, 8'h81, 3'b100);
    tbl[12] = mk(4'b0111, 1'b1, 8'h82, 3'b101);
    tbl[13] = mk(4'b0111, 1'b1, 8'h83, 3'b010);
    tbl[14] = mk(4'b0111, 1'b1, 8'h04, 3'b010);
    tbl[15] = mk(4'b1111, 1'b0, 8'h00, 3'b000);
    tbl[16] = mk(4'b0111, 1'b0, 8'h00, 3'b010);
    tbl[17] = mk(4'b0111, 1'b1, 8'h05, 3'b010);
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].in[3]; en0 = tbl[i].in[2]; en1 = tbl[i].in[1]; rdy = tbl[i].in[0];
      step();
      chk($sformatf("vec%0d_valid", i), {31'h0, valid_o}, {31'h0, tbl[i].vo});
      chk($sformatf("vec%0d_data", i), {24'h0, data_o}, {24'h0, tbl[i].d});
      chk($sformatf("vec%0d_sel", i), {31'h0, select_o}, {31'h0, tbl[i].fl[2]});
      chk($sformatf("vec%0d_rdy0", i), {31'h0, ready_0_o}, {31'h0, tbl[i].fl[1]});
      chk($sformatf("vec%0d_rdy1", i), {31'h0, ready_1_o}, {31'h0, tbl[i].fl[0]});
    end
    reset_all();
    use_sb = 1'b1;
    base0 = 8'h10; lim0 = 8; en0 = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back(8'h10 + 8'(i));
    for (int n = 0; n < 40 && consumed < 8; n++) begin
      step();
      if (valid_o) chk("single_sel", {31'h0, select_o}, 32'h0);
    end
    chk("single_count", consumed, 8);
    chk("single_nobubble", last_c - first_c, 7);
    reset_all();
    en0 = 1'b1; en1 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 4; j++) sb.push_back(8'(4 * b + j));
      for (int j = 0; j < 4; j++) sb.push_back(8'h80 + 8'(4 * b + j));
    end
    for (int n = 0; n < 300 && consumed < 32; n++) begin
      rdy = $urandom_range(0, 3) != 0;
      step();
    end
    chk("contend_count", consumed, 32);
    reset_all();
    rdy = 1'b1; lim1 = 2; en1 = 1'b1;
    sb.push_back(8'h80); sb.push_back(8'h81);
    for (int j = 0; j < 4; j++) sb.push_back(8'(j));
    step();
    chk("wd_grant1", {31'h0, select_o}, 32'h1);
    en0 = 1'b1;
    step();
    step();
    chk("wd_still1", {31'h0, select_o}, 32'h1);
    step();
    chk("wd_sel0", {31'h0, select_o}, 32'h0);
    chk("wd_rdy0", {31'h0, ready_0_o}, 32'h1);
    for (int n = 0; n < 30 && consumed < 6; n++) step();
    chk("wd_count", consumed, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
